// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-port bundle for mem_port_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 7
);
    localparam int BPW = WORD_BITS / 8;
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ-1:0]           req_rd;
    logic [NUM_REQ*WORD_BITS-1:0] req_wr_data;
    logic [NUM_REQ*BPW-1:0]       req_wr_en;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [WORD_BITS-1:0]         rsp_rd_data;
    logic [IDW-1:0]               grant_id;
    logic                         mem_reset;
    logic [ADDR_BITS-1:0]         mem_address;
    logic                         mem_rd_en;
    logic [WORD_BITS-1:0]         mem_wr_data;
    logic [BPW-1:0]               mem_wr_en;
    logic [WORD_BITS-1:0]         mem_rd_data;

    modport slave (
        input  req_valid, req_addr, req_rd,
        input  req_wr_data, req_wr_en,
        input  mem_rd_data,
        output req_ready, rsp_valid, rsp_rd_data,
        output grant_id, mem_reset, mem_address,
        output mem_rd_en, mem_wr_data, mem_wr_en
    );

    modport master (
        output req_valid, req_addr, req_rd,
        output req_wr_data, req_wr_en,
        output mem_rd_data,
        input  req_ready, rsp_valid, rsp_rd_data,
        input  grant_id, mem_reset, mem_address,
        input  mem_rd_en, mem_wr_data, mem_wr_en
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Ports: clk, reset_n (async active-low), bus (slave: requests, responses, memory port).
module mem_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 7
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam int BPW = WORD_BITS / 8;
    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_grant_id;
    logic           r_pend_valid;
    logic [IDW-1:0] r_pend_id;
    logic           r_mem_reset;

    logic           w_grant;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_idx;

    // Rotating priority scan; first valid at or after rr_ptr wins.
    always_comb begin
        w_grant = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_grant && bus.req_valid[w_idx]) begin
                w_grant = 1'b1;
                w_win   = w_idx;
            end
        end
        // No grants while the memory is still held in reset.
        if (r_mem_reset) begin
            w_grant = 1'b0;
        end
    end

    always_comb begin
        bus.req_ready   = '0;
        bus.mem_address = '0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_data = '0;
        bus.mem_wr_en   = '0;
        if (w_grant) begin
            bus.req_ready   = NUM_REQ'(1) << w_win;
            bus.mem_address = bus.req_addr[w_win*ADDR_BITS +: ADDR_BITS];
            bus.mem_rd_en   = bus.req_rd[w_win];
            bus.mem_wr_data = bus.req_wr_data[w_win*WORD_BITS +: WORD_BITS];
            bus.mem_wr_en   = bus.req_wr_en[w_win*BPW +: BPW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
            r_mem_reset  <= 1'b1;
        end else begin
            r_mem_reset  <= 1'b0;
            r_pend_valid <= w_grant && bus.req_rd[w_win];
            if (w_grant) begin
                r_rr_ptr   <= IDW'((int'(w_win) + 1) % NUM_REQ);
                r_grant_id <= w_win;
                if (bus.req_rd[w_win]) begin
                    r_pend_id <= w_win;
                end
            end
        end
    end

    // Memory read latency is one cycle, so data is passed straight through.
    assign bus.rsp_valid   = r_pend_valid ? (NUM_REQ'(1) << r_pend_id) : '0;
    assign bus.rsp_rd_data = bus.mem_rd_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.mem_reset   = r_mem_reset;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-masked
// read-before-write memory model on the port.
module tb_mem_port_arbiter;
    logic clk;
    logic reset_n;

    mem_port_arbiter_if #(
        .NUM_REQ(4), .WORD_BITS(32), .ADDR_BITS(7)
    ) bus ();

    mem_port_arbiter #(
        .NUM_REQ(4), .WORD_BITS(32), .ADDR_BITS(7)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [32];
    logic        pre_en;
    logic [4:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_data;
        end
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= mem[bus.mem_address[6:2]];
        end
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_wr_en[b]) begin
                mem[bus.mem_address[6:2]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [31:0] wd);
        bus.req_addr[i*7 +: 7]      = a;
        bus.req_wr_data[i*32 +: 32] = wd;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  rd;
        logic [15:0] wen;
        logic [3:0]  e_ready;
        logic [6:0]  e_addr;
        logic        e_rd_en;
        logic [3:0]  e_wen;
        logic [31:0] e_wdata;
        logic [3:0]  e_rsp;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 7'h00, 1'b0, 4'h0, 32'h0,        4'b0000, 32'h0};
        vecs[1]  = '{4'b1111, 4'b1111, 16'h0000, 4'b0001, 7'h10, 1'b1, 4'h0, 32'h55667780, 4'b0000, 32'h0};
        vecs[2]  = '{4'b1111, 4'b1111, 16'h0000, 4'b0010, 7'h14, 1'b1, 4'h0, 32'h55667781, 4'b0001, 32'hA0000000};
        vecs[3]  = '{4'b1111, 4'b1111, 16'h0000, 4'b0100, 7'h18, 1'b1, 4'h0, 32'h55667782, 4'b0010, 32'hA0000001};
        vecs[4]  = '{4'b1111, 4'b1111, 16'h0000, 4'b1000, 7'h1C, 1'b1, 4'h0, 32'h55667783, 4'b0100, 32'hA0000002};
        vecs[5]  = '{4'b1010, 4'b1010, 16'h0000, 4'b0010, 7'h14, 1'b1, 4'h0, 32'h55667781, 4'b1000, 32'hA0000003};
        vecs[6]  = '{4'b1010, 4'b1010, 16'h0000, 4'b1000, 7'h1C, 1'b1, 4'h0, 32'h55667783, 4'b0010, 32'hA0000001};
        vecs[7]  = '{4'b0001, 4'b0000, 16'h0000, 4'b0001, 7'h10, 1'b0, 4'h0, 32'h55667780, 4'b1000, 32'hA0000003};
        vecs[8]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 7'h00, 1'b0, 4'h0, 32'h0,        4'b0000, 32'h0};
        vecs[9]  = '{4'b0001, 4'b0000, 16'h0000, 4'b0001, 7'h10, 1'b0, 4'h0, 32'h55667780, 4'b0000, 32'h0};
        vecs[10] = '{4'b0100, 4'b0000, 16'h0300, 4'b0100, 7'h18, 1'b0, 4'h3, 32'h55667782, 4'b0000, 32'h0};
        vecs[11] = '{4'b0100, 4'b0100, 16'h0000, 4'b0100, 7'h18, 1'b1, 4'h0, 32'h55667782, 4'b0000, 32'h0};
        vecs[12] = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 7'h00, 1'b0, 4'h0, 32'h0,        4'b0100, 32'hA0007782};

        pre_en      = 1'b0;
        pre_idx     = '0;
        pre_data    = '0;
        reset_n     = 1'b0;
        bus.req_valid   = 4'b1111;
        bus.req_rd      = 4'b1111;
        bus.req_wr_en   = '0;
        bus.req_addr    = '0;
        bus.req_wr_data = '0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 7'(8'h10 + 8'(4*i)), 32'h55667780 + 32'(i));
        end

        preload(5'd3, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            preload(5'(4 + i), 32'hA0000000 + 32'(i));
        end
        preload(5'd8, 32'h0);
        preload(5'd9, 32'h12345678);

        // Reset state with every requester asking.
        #1;
        chk("rst_mem_reset", 32'(bus.mem_reset), 32'h1);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 32'h0);
        chk("rst_addr", 32'(bus.mem_address), 32'h0);
        chk("rst_rsp", 32'(bus.rsp_valid), 32'h0);
        chk("rst_gid", 32'(bus.grant_id), 32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_mem_reset", 32'(bus.mem_reset), 32'h1);
        chk("rel_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.req_rd    = 4'b0000;
        #1;
        chk("rel_mem_reset_clr", 32'(bus.mem_reset), 32'h0);

        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            bus.req_valid = vecs[v].valid;
            bus.req_rd    = vecs[v].rd;
            bus.req_wr_en = vecs[v].wen;
            #1;
            chk($sformatf("v%0d_ready", v), 32'(bus.req_ready), 32'(vecs[v].e_ready));
            chk($sformatf("v%0d_addr", v), 32'(bus.mem_address), 32'(vecs[v].e_addr));
            chk($sformatf("v%0d_rd_en", v), 32'(bus.mem_rd_en), 32'(vecs[v].e_rd_en));
            chk($sformatf("v%0d_wen", v), 32'(bus.mem_wr_en), 32'(vecs[v].e_wen));
            chk($sformatf("v%0d_wdata", v), bus.mem_wr_data, vecs[v].e_wdata);
            chk($sformatf("v%0d_rsp", v), 32'(bus.rsp_valid), 32'(vecs[v].e_rsp));
            if (vecs[v].e_rsp != 4'b0000) begin
                chk($sformatf("v%0d_rdata", v), bus.rsp_rd_data, vecs[v].e_rdata);
            end
        end

        // Single read of word 3 by requester 2.
        @(negedge clk);
        set_req(2, 7'h0C, 32'h0);
        bus.req_valid = 4'b0100;
        bus.req_rd    = 4'b0100;
        bus.req_wr_en = '0;
        #1;
        chk("sr_ready", 32'(bus.req_ready), 32'h4);
        chk("sr_addr", 32'(bus.mem_address), 32'h0C);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.req_rd    = 4'b0000;
        #1;
        chk("sr_rsp", 32'(bus.rsp_valid), 32'h4);
        chk("sr_rdata", bus.rsp_rd_data, 32'hDEADBEEF);
        chk("sr_gid", 32'(bus.grant_id), 32'h2);

        // Byte-masked write, then read back.
        @(negedge clk);
        set_req(1, 7'h20, 32'h11223344);
        bus.req_valid = 4'b0010;
        bus.req_rd    = 4'b0000;
        bus.req_wr_en = 16'h0050;
        #1;
        chk("bw_ready", 32'(bus.req_ready), 32'h2);
        chk("bw_wen", 32'(bus.mem_wr_en), 32'h5);
        @(negedge clk);
        bus.req_rd    = 4'b0010;
        bus.req_wr_en = '0;
        #1;
        chk("bw_rsp_none", 32'(bus.rsp_valid), 32'h0);
        chk("bw_rd_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.req_rd    = 4'b0000;
        #1;
        chk("bw_rsp", 32'(bus.rsp_valid), 32'h2);
        chk("bw_rdata", bus.rsp_rd_data, 32'h00220044);

        // Combined read+write returns pre-write data.
        @(negedge clk);
        set_req(0, 7'h24, 32'hCAFEF00D);
        bus.req_valid = 4'b0001;
        bus.req_rd    = 4'b0001;
        bus.req_wr_en = 16'h000F;
        #1;
        chk("rw_ready", 32'(bus.req_ready), 32'h1);
        chk("rw_wen", 32'(bus.mem_wr_en), 32'hF);
        @(negedge clk);
        bus.req_wr_en = '0;
        #1;
        chk("rw_rsp", 32'(bus.rsp_valid), 32'h1);
        chk("rw_rdata_old", bus.rsp_rd_data, 32'h12345678);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.req_rd    = 4'b0000;
        #1;
        chk("rw_rsp2", 32'(bus.rsp_valid), 32'h1);
        chk("rw_rdata_new", bus.rsp_rd_data, 32'hCAFEF00D);

        // Reset right after a read grant drops the response.
        @(negedge clk);
        set_req(1, 7'h10, 32'h0);
        bus.req_valid = 4'b0010;
        bus.req_rd    = 4'b0010;
        #1;
        chk("mr_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.req_rd    = 4'b0000;
        reset_n       = 1'b0;
        #1;
        chk("mr_rsp", 32'(bus.rsp_valid), 32'h0);
        chk("mr_mem_reset", 32'(bus.mem_reset), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        chk("mr_mem_reset_clr", 32'(bus.mem_reset), 32'h0);
        chk("mr_first_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        chk("mr_rsp_none", 32'(bus.rsp_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the dual-port main memory between NUM_REQ requesters, e.g. GPU cores, DMA and the video scan-out.
- Each requester issues single-word read and/or byte-masked write requests over a valid/ready handshake.
- A round-robin grant picks one request per cycle and drives it onto the memory port.
- Read data returns one cycle later (the memory's read latency), tagged to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WORD_BITS, 32, memory word width; BYTES_PER_WORD = WORD_BITS/8 (derived)
- ADDR_BITS, 7, byte-address width of the memory port (128-byte memory)

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  grant; request i is accepted in a cycle where req_valid[i] & req_ready[i]
- req_addr  in  NUM_REQ*ADDR_BITS  byte address, flattened, requester i at [i*ADDR_BITS +: ADDR_BITS]
- req_rd  in  NUM_REQ  request includes a read
- req_wr_data  in  NUM_REQ*WORD_BITS  write data, flattened
- req_wr_en  in  NUM_REQ*BYTES_PER_WORD  byte write strobes, flattened
- rsp_valid  out  NUM_REQ  one-cycle pulse: read data for requester i is on rsp_rd_data
- rsp_rd_data  out  WORD_BITS  read data, shared by all requesters
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted request (debug)
- mem_reset  out  1  to the memory port reset
- mem_address  out  ADDR_BITS  to the memory port address
- mem_rd_en  out  1  to the memory port read enable
- mem_wr_data  out  WORD_BITS  to the memory port write data
- mem_wr_en  out  BYTES_PER_WORD  to the memory port byte write enables
- mem_rd_data  in  WORD_BITS  from the memory port, valid the cycle after mem_rd_en

Behaviour:
- Reset (reset_n low, asynchronous):
  - rr_ptr=0, grant_id=0, pend_valid=0, pend_id=0, mem_reset=1.
  - All req_ready, rsp_valid, mem_rd_en and mem_wr_en are 0; mem_address and mem_wr_data are 0.
- mem_reset is a flop, set asynchronously by reset and cleared on the first clk edge after reset_n rises. While it is 1, no grants are issued.
- Arbitration (combinational, one grant per cycle):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - Only the winner sees req_ready=1. req_ready never asserts for a requester whose req_valid is 0.
- Memory drive, same cycle as the grant:
  - mem_address = winner's addr; mem_rd_en = winner's rd; mem_wr_en = winner's wr_en; mem_wr_data = winner's wr_data.
  - With no grant: mem_rd_en=0, mem_wr_en=0, mem_address=0, mem_wr_data=0.
- On an accept at a clk edge:
  - rr_ptr <= (winner+1) mod NUM_REQ; grant_id <= winner.
  - With no accept, rr_ptr and grant_id hold.
- Read return:
  - An accepted read sets pend_valid<=1 and pend_id<=winner; otherwise pend_valid<=0.
  - Next cycle: rsp_valid = onehot(pend_id) when pend_valid, else 0. rsp_rd_data = mem_rd_data, passed through combinationally.
  - Fixed latency of exactly 1 cycle, with no backpressure; requesters must accept rsp_valid when it fires.
- Back-to-back reads: one read per cycle at full throughput; responses come out in grant order.
- Read and write in one request: allowed. The response carries pre-write data (read-before-write port behaviour).
- rd=0 with wr_en=0: accepted as a no-op; no rsp_valid, no memory activity.
- Write-only request: no response.
- Address bits below the word index are ignored by the memory and passed through unchanged.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0... A valid requester waits at most NUM_REQ-1 cycles.
- Requester inputs must stay stable while req_valid=1 and not yet accepted; the arbiter does not register them.
- Reset mid-operation: a pending response is dropped and rsp_valid drops immediately. After reset, arbitration restarts at requester 0.

Test Plan:
- Reset release: assert reset_n=0 then release -> mem_reset=1 until the first edge, then 0; no req_ready before that; all outputs 0 during reset.
- Single read: preload word 3 = 0xDEADBEEF; req 2 reads addr 0x0C -> req_ready[2] in the same cycle; next cycle rsp_valid=0b0100 and rsp_rd_data=0xDEADBEEF.
- Round-robin: all 4 requesters hold valid reads for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each rsp_valid one-hot matches the prior grant.
- Byte write then read: req 1 writes 0x11223344 with wr_en=0b0101 to a word holding 0 -> a later read returns 0x00220044.
- Combined read+write: req 0 sends rd=1 and wr_en=0xF with 0xCAFEF00D to a word holding 0x12345678 -> rsp 0x12345678; a later read returns 0xCAFEF00D.
- Mid-op reset: assert reset_n low the cycle after a read grant -> rsp_valid stays 0; after release the first grant goes to requester 0 even if rr_ptr was 2.
